muldiv_hilo: RTL and testbench
==============================

// Module: muldiv_hilo
// PURPOSE
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   Sits beside alu in the execute stage and takes the same register-file operands.
//   Replaces the single-cycle combinational MULT/DIV path with a shift-add multiplier and a restoring divider.
//   Serves MFHI/MFLO reads via the Hi/Lo outputs and stalls the control FSM through Busy.
// PARAMETERS
//   WIDTH   32  operand width; Hi/Lo are WIDTH each, the iteration count equals WIDTH
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   Start      in   1      request strobe, sampled only when Busy=0
//   Op         in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   Operand1   in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
//   Operand2   in   WIDTH  rt value (multiplier / divisor)
//   Busy       out  1      operation in flight, Start ignored
//   Done       out  1      one-cycle pulse: Hi/Lo hold the new result
//   DivByZero  out  1      pulses with Done when DIV/DIVU had Operand2==0
//   Hi         out  WIDTH  HI register
//   Lo         out  WIDTH  LO register
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0, counter=0.
//   Reset mid-operation aborts the operation immediately; no partial result reaches Hi/Lo.
//   FSM states: IDLE -> MUL|DIV -> FIX -> IDLE.
//   IDLE: on Start=1 edge E0:
//     MTHI/MTLO: Hi/Lo <= Operand1 at E0, stay in IDLE, Busy stays 0, no Done pulse.
//     Op 6-7: ignored.
//     MULT/MULTU/DIV/DIVU: latch operands; counter=0; Busy=1 from E0.
//       Signed ops latch magnitudes and record the result signs.
//     DIV/DIVU with Operand2==0: go straight to FIX; no iterations.
//   MUL: one shift-add step per edge, WIDTH steps (E1..E_WIDTH), then FIX.
//   DIV: one restore step per edge, WIDTH steps (E1..E_WIDTH), then FIX.
//   FIX (one edge, E_WIDTH+1):
//     Apply sign correction and write Hi/Lo.
//     Done=1 for exactly the following cycle; Busy=0 from the same edge.
//   Latency: Start edge to Done high = WIDTH+1 edges (33 at default); divide-by-zero = 1 edge.
//   Results:
//     MULT/MULTU: {Hi,Lo} = full 2*WIDTH product; MULT is two's complement.
//     DIVU: Lo = quotient, Hi = remainder.
//     DIV: quotient truncates toward zero; remainder takes the dividend's sign.
//     DIV overflow, -2^31 / -1: Lo=32'h80000000, Hi=0.
//     Divide by zero: Lo=32'hFFFFFFFF, Hi=Operand1; DivByZero=1 with Done.
//   Start while Busy=1 is dropped, with no queueing. Operands are not re-sampled during the operation.
//   Hi/Lo stay stable and readable while Busy=1; the controller must stall MFHI/MFLO until Done.
//   Start may assert in the same cycle Done is high; it is accepted normally.
// CONFIGURATION
//   MULDIV_FAST_MULT_EN defined:
//     MULT/MULTU compute the full product in MUL in one edge, then FIX.
//     Latency 2 edges; DIV path unchanged.
//   MULDIV_FAST_MULT_EN undefined: iterative shift-add multiplier, WIDTH+1 edge latency.
//     No '*' operator is synthesised.
// TESTING
//   1. Reset: reset_n=0 mid-DIV (counter=10) -> Busy=0, Hi=Lo=0 at once; no Done afterwards.
//   2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
//      Done at edge 33 (edge 2 with MULDIV_FAST_MULT_EN).
//   3. MULT -3*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
//      DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
//   4. DIVU 100/0 -> Done after 1 edge, DivByZero=1, Lo=0xFFFFFFFF, Hi=100.
//      DIV 0x80000000/-1 -> Lo=0x80000000, Hi=0.
//   5. Start MULT pulsed again at edge 5 while Busy -> ignored; first result intact.
//      MTHI 0x1234 when idle -> Hi=0x1234 next cycle, Busy never rises.
//   6. Back-to-back: new DIVU Start in the Done cycle -> accepted; second Done 33 edges later.

Source files
------------

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit with architectural HI/LO registers
//   clk, reset_n (async active-low)
//   Start, Op[2:0] (0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6-7 no-op), Operand1, Operand2
//   Busy, Done, DivByZero, Hi, Lo
//   MULDIV_FAST_MULT_EN: single-edge multiply instead of the shift-add iteration
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, nxt;
  // p holds {acc, multiplier} while multiplying and {remainder, quotient} while dividing
  logic [2*WIDTH-1:0] p, pn;
  logic [WIDTH-1:0] b, m1, m2, qn, rn, hi_fix, lo_fix;
  logic [WIDTH:0] rsh, diff;
  logic [CW-1:0] cnt;
  logic mul_op, neg_q, neg_r, dz, s1, s2, is_md, div0, last;
`ifndef MULDIV_FAST_MULT_EN
  logic [WIDTH:0] add;
  assign add = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? b : '0};
`endif
  assign is_md = !Op[2];
  assign div0 = Op[1] && Operand2 == '0;
  assign s1 = !Op[0] && Operand1[WIDTH-1];
  assign s2 = !Op[0] && Operand2[WIDTH-1];
  assign m1 = s1 ? -Operand1 : Operand1;
  assign m2 = s2 ? -Operand2 : Operand2;
  assign last = cnt == CW'(WIDTH - 1);
  assign rsh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign diff = rsh - {1'b0, b};
  assign pn = -p;
  assign qn = -p[WIDTH-1:0];
  assign rn = -p[2*WIDTH-1:WIDTH];
  assign hi_fix = mul_op ? (neg_q ? pn[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH])
                         : (neg_r ? rn : p[2*WIDTH-1:WIDTH]);
  assign lo_fix = mul_op ? (neg_q ? pn[WIDTH-1:0] : p[WIDTH-1:0])
                         : (neg_q ? qn : p[WIDTH-1:0]);
  assign Busy = state != IDLE;
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = (Start && is_md) ? (div0 ? FIX : (Op[1] ? DIV : MUL)) : IDLE;
    else if (state == FIX)
      nxt = IDLE;
    else if (last || (FAST && state == MUL))
      nxt = FIX;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
      b <= '0;
      cnt <= '0;
      mul_op <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      Done <= 1'b0;
      DivByZero <= 1'b0;
      Hi <= '0;
      Lo <= '0;
    end else begin
      Done <= state == FIX;
      DivByZero <= state == FIX && dz;
      if (state == IDLE && Start) begin
        if (Op == 3'd4) Hi <= Operand1;
        if (Op == 3'd5) Lo <= Operand1;
        if (is_md) begin
          cnt <= '0;
          mul_op <= !Op[1];
          dz <= div0;
          neg_q <= !div0 && (s1 ^ s2);
          neg_r <= !div0 && s1;
          b <= m2;
          // divide-by-zero parks the final {Hi,Lo} in p so FIX writes it unchanged
          p <= div0 ? {Operand1, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, m1};
        end
      end else if (state == MUL) begin
`ifdef MULDIV_FAST_MULT_EN
        p <= {{WIDTH{1'b0}}, p[WIDTH-1:0]} * {{WIDTH{1'b0}}, b};
`else
        p <= {add, p[WIDTH-1:1]};
`endif
        cnt <= cnt + CW'(1);
      end else if (state == DIV) begin
        p <= diff[WIDTH] ? {rsh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                         : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        cnt <= cnt + CW'(1);
      end else if (state == FIX) begin
        Hi <= hi_fix;
        Lo <= lo_fix;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: scoreboard bench for muldiv_hilo against an arithmetic reference model
module tb_muldiv_hilo;
  logic clk = 1'b0, reset_n = 1'b0, Start = 1'b0;
  logic [2:0] Op = '0;
  logic [31:0] Operand1 = '0, Operand2 = '0;
  logic Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int due;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, edge_cnt = 0, done_cnt = 0;
  logic [31:0] model_hi = '0, model_lo = '0;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MLAT = 2;
`else
  localparam int MLAT = 33;
`endif
  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Op(Op),
    .Operand1(Operand1), .Operand2(Operand2), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d, input int due);
    exp_t e;
    logic [63:0] pr;
    int sa, sd;
    e.hi = '0; e.lo = '0; e.dz = 1'b0; e.due = due;
    sa = a; sd = d;
    if (op == 3'd0) begin
      pr = longint'(sa) * longint'(sd);
      e.hi = pr[63:32]; e.lo = pr[31:0];
    end else if (op == 3'd1) begin
      pr = {32'd0, a} * {32'd0, d};
      e.hi = pr[63:32]; e.lo = pr[31:0];
    end else if (d == 32'd0) begin
      e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
    end else if (op == 3'd2) begin
      if (a == 32'h80000000 && d == 32'hFFFFFFFF) begin
        e.lo = 32'h80000000; e.hi = '0;
      end else begin
        e.lo = 32'(sa / sd); e.hi = 32'(sa % sd);
      end
    end else begin
      e.lo = a / d; e.hi = a % d;
    end
    return e;
  endfunction
  always @(negedge clk) if (reset_n) begin
    if (Done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 64'(Done), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", 64'(Hi), 64'(e.hi));
        chk("lo", 64'(Lo), 64'(e.lo));
        chk("divbyzero", 64'(DivByZero), 64'(e.dz));
        chk("latency", 64'(edge_cnt), 64'(e.due));
        model_hi = e.hi;
        model_lo = e.lo;
      end
    end else begin
      if (sb.size() != 0 && edge_cnt > sb[0].due) begin
        chk("done_timeout", 64'(Done), 64'd1);
        void'(sb.pop_front());
      end
      if (DivByZero) chk("dz_without_done", 64'(DivByZero), 64'd0);
      if (Busy) chk("hilo_stable", {Hi, Lo}, {model_hi, model_lo});
    end
  end
  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d, input bit now);
    int n = 0;
    int lat;
    if (!now) begin
      @(negedge clk);
      while (Busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (Busy) chk("issue_busy_timeout", 64'(Busy), 64'd0);
    end
    Start = 1'b1; Op = op; Operand1 = a; Operand2 = d;
    lat = (op >= 3'd2 && d == 32'd0) ? 1 : (op < 3'd2 ? MLAT : 33);
    if (op < 3'd4) sb.push_back(model(op, a, d, edge_cnt + 1 + lat));
    @(posedge clk);
    #1 Start = 1'b0;
    Operand1 = $urandom; Operand2 = $urandom;
    if (op == 3'd4) model_hi = a;
    if (op == 3'd5) model_lo = a;
    if (op >= 3'd4) begin
      @(negedge clk);
      chk("mt_busy", 64'(Busy), 64'd0);
      chk("mt_hilo", {Hi, Lo}, {model_hi, model_lo});
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (Busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(Busy), 64'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
  initial begin
    int d0, n;
    logic [2:0] op;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {31'd0, Busy, Done, DivByZero, Hi}, {31'd0, 3'b000, 32'd0});
    chk("reset_lo", 64'(Lo), 64'd0);
    reset_n = 1'b1;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    chk("multu_max", {Hi, Lo}, 64'hFFFFFFFE_00000001);
    issue(3'd0, -32'sd3, 32'd5, 1'b0);
    wait_idle();
    chk("mult_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);
    issue(3'd2, -32'sd7, 32'd2, 1'b0);
    wait_idle();
    chk("div_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd3, 32'd100, 32'd0, 1'b0);
    wait_idle();
    chk("divu_zero", {Hi, Lo}, 64'h00000064_FFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    chk("div_ovf", {Hi, Lo}, 64'h00000000_80000000);
    issue(3'd0, 32'd1234567, -32'sd89, 1'b0);
    repeat (4) @(negedge clk);
    Start = 1'b1; Op = 3'd0; Operand1 = 32'd7; Operand2 = 32'd9;
    chk("busy_during_mult", 64'(Busy), 64'd1);
    @(negedge clk);
    Start = 1'b0;
    issue(3'd4, 32'h1234, 32'd0, 1'b0);
    chk("mthi", 64'(Hi), 64'h1234);
    issue(3'd5, 32'hCAFE, 32'd0, 1'b0);
    issue(3'd6, 32'hDEAD, 32'd1, 1'b0);
    issue(3'd3, 32'd1000000, 32'd37, 1'b0);
    n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 64'(Done), 64'd1);
    issue(3'd3, 32'hFFFFFFF0, 32'd3, 1'b1);
    issue(3'd2, 32'd1000, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    sb.delete();
    model_hi = '0; model_lo = '0;
    #1 chk("abort_state", {31'd0, Busy, Hi}, 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
    for (int i = 0; i < 120; i++) begin
      n = $urandom_range(0, 9);
      op = n < 8 ? 3'(n % 4) : 3'(4 + $urandom_range(0, 3));
      issue(op, rnd(), rnd(), 1'b0);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
